div_gen_0: RTL

Sequential signed divider for the FDTD ALU. It is the inverse of the registered multiplier: it takes a 2*WIDTH-bit signed product-width dividend and a WIDTH-bit signed divisor, and returns a WIDTH-bit quotient and remainder. It uses a radix-2 restoring algorithm on magnitudes, with a START/BUSY/DONE handshake and the same CE clock-enable semantics as the other ALU primitives.

---
 rtl/div_gen_0.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/div_gen_0.sv
// rtl/div_gen_0.sv - sequential signed restoring divider (2W/W), optional DIV_GEN_EARLY_EXIT_EN
module div_gen_0 #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CE,
    input  logic                 START,
    input  logic [2*WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]     B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     R,
    output logic                 OVF,
    output logic                 DIV0
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // a_lo_q starts as the low half of |A| and fills up with quotient bits as it shifts out
    logic [WIDTH-1:0] a_lo_q, a_lo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] a_raw_lo_q, a_raw_lo_d;
    logic             sgn_a_q, sgn_a_d;
    logic             sgn_q_q, sgn_q_d;
    logic             pre_ovf_q, pre_ovf_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               pre_ovf_in;
    logic               b_zero_in;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   diff;
    logic               trial_ge;
    logic               ovf_fix;

    // Operand magnitudes, the precheck and one restoring-division step
    always_comb begin
        a_abs      = A[2*WIDTH-1] ? -A : A;
        b_abs      = B[WIDTH-1] ? -B : B;
        pre_ovf_in = (a_abs[2*WIDTH-1:WIDTH] >= b_abs);
        b_zero_in  = (B == '0);
        trial      = {rem_q, a_lo_q[WIDTH-1]};
        trial_ge   = (trial >= {1'b0, b_mag_q});
        diff       = trial[WIDTH-1:0] - b_mag_q;
        ovf_fix    = pre_ovf_q
                   | (~sgn_q_q & (a_lo_q > MAX_POS))
                   | ( sgn_q_q & (a_lo_q > MIN_NEG));
    end

    // Next-state and datapath updates; nothing moves while CE is low
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_lo_d     = a_lo_q;
        rem_d      = rem_q;
        b_mag_d    = b_mag_q;
        a_raw_lo_d = a_raw_lo_q;
        sgn_a_d    = sgn_a_q;
        sgn_q_d    = sgn_q_q;
        pre_ovf_d  = pre_ovf_q;
        b_zero_d   = b_zero_q;
        q_d        = q_q;
        r_d        = r_q;
        ovf_d      = ovf_q;
        div0_d     = div0_q;
        done_d     = done_q;

        if (CE) begin
            done_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        rem_d      = a_abs[2*WIDTH-1:WIDTH];
                        a_lo_d     = a_abs[WIDTH-1:0];
                        b_mag_d    = b_abs;
                        a_raw_lo_d = A[WIDTH-1:0];
                        sgn_a_d    = A[2*WIDTH-1];
                        sgn_q_d    = A[2*WIDTH-1] ^ B[WIDTH-1];
                        pre_ovf_d  = pre_ovf_in;
                        b_zero_d   = b_zero_in;
                        cnt_d      = '0;
`ifdef DIV_GEN_EARLY_EXIT_EN
                        state_d    = (pre_ovf_in | b_zero_in) ? S_FIX : S_CALC;
`else
                        state_d    = S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    rem_d  = trial_ge ? diff : trial[WIDTH-1:0];
                    a_lo_d = {a_lo_q[WIDTH-2:0], trial_ge};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (b_zero_q) begin
                        div0_d = 1'b1;
                        ovf_d  = 1'b0;
                        q_d    = sgn_a_q ? MIN_NEG : MAX_POS;
                        r_d    = a_raw_lo_q;
                    end else if (ovf_fix) begin
                        div0_d = 1'b0;
                        ovf_d  = 1'b1;
                        q_d    = sgn_q_q ? MIN_NEG : MAX_POS;
                        r_d    = '0;
                    end else begin
                        div0_d = 1'b0;
                        ovf_d  = 1'b0;
                        q_d    = sgn_q_q ? -a_lo_q : a_lo_q;
                        r_d    = sgn_a_q ? -rem_q : rem_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and result registers, asynchronously cleared
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_lo_q     <= '0;
            rem_q      <= '0;
            b_mag_q    <= '0;
            a_raw_lo_q <= '0;
            sgn_a_q    <= 1'b0;
            sgn_q_q    <= 1'b0;
            pre_ovf_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            ovf_q      <= 1'b0;
            div0_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_lo_q     <= a_lo_d;
            rem_q      <= rem_d;
            b_mag_q    <= b_mag_d;
            a_raw_lo_q <= a_raw_lo_d;
            sgn_a_q    <= sgn_a_d;
            sgn_q_q    <= sgn_q_d;
            pre_ovf_q  <= pre_ovf_d;
            b_zero_q   <= b_zero_d;
            q_q        <= q_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
            div0_q     <= div0_d;
            done_q     <= done_d;
        end
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign OVF  = ovf_q;
    assign DIV0 = div0_q;

endmodule
